rtc_bus_reader: RTL
===================

RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 SHALL have parameter T_PHASE, default 10, giving clock cycles per bus phase (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request one register read; sampled only in IDLE.
REQ-005 SHALL have port addr, input, 8 bits: RTC register address; latched when start is accepted.
REQ-006 SHALL have port ad_in, input, 8 bits: multiplexed address/data bus value from the RTC chip.
REQ-007 SHALL have port ad_out, output, 8 bits: address value driven onto the bus.
REQ-008 SHALL have port ad_oe, output, 1 bit: bus drive enable; the top level tristates the pad when this is 0.
REQ-009 SHALL have ports cs_n, rd_n, wr_n and a_d_n, outputs, 1 bit each, all active-low: chip select, read strobe, write strobe and address/data select (0 = address phase).
REQ-010 SHALL have port data_out, output, 8 bits: the last register value read.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when data_out has been updated.

Function
REQ-013 SHALL implement the states IDLE, A_SETUP, A_WR, A_HOLD, TURN, D_CS, D_RD, D_HOLD and DONE.
REQ-014 SHALL keep each of the seven states from A_SETUP through D_HOLD for exactly T_PHASE cycles, timed by a phase counter that reloads on every state change; IDLE and DONE SHALL last one cycle, except that IDLE persists while start is low.
REQ-015 IDLE: cs_n=1, rd_n=1, wr_n=1, a_d_n=1, ad_oe=0; when start=1, addr SHALL be latched into an internal register and the next state SHALL be A_SETUP.
REQ-016 A_SETUP: cs_n=0, a_d_n=0, ad_oe=1, ad_out=latched addr, wr_n=1, rd_n=1.
REQ-017 A_WR: same as A_SETUP, with wr_n=0.
REQ-018 A_HOLD: same as A_SETUP, with wr_n=1; ad_out and ad_oe SHALL remain stable.
REQ-019 TURN: cs_n=1, a_d_n=1, ad_oe=0, all strobes high (bus turnaround).
REQ-020 D_CS: cs_n=0, a_d_n=1, ad_oe=0, rd_n=1.
REQ-021 D_RD: cs_n=0, rd_n=0, ad_oe=0; on the last D_RD cycle, ad_in SHALL be registered into data_out.
REQ-022 D_HOLD: cs_n=0, rd_n=1, ad_oe=0.
REQ-023 DONE: all strobes inactive, ad_oe=0, done=1 for exactly one cycle, then IDLE.
REQ-024 Timing from the start-accept edge (cycle 0): A_SETUP occupies cycles 1..T_PHASE; D_HOLD ends at cycle 7*T_PHASE; done=1 in cycle 7*T_PHASE+1. Consecutive reads are therefore separated by at least one IDLE cycle.
REQ-025 ad_oe and rd_n SHALL never be 0 in the same cycle; wr_n and rd_n SHALL never both be 0.
REQ-026 start while busy=1 SHALL be ignored and not queued; addr changes while busy SHALL have no effect on the transaction in progress.
REQ-027 data_out SHALL hold its value between reads and change only in the D_RD capture cycle or on reset.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 When reset=1 at a clock edge, on the next cycle: state=IDLE, phase counter=0, latched addr=0x00, data_out=0x00, ad_out=0x00, ad_oe=0, cs_n=rd_n=wr_n=a_d_n=1, busy=0, done=0.
REQ-030 Reset asserted mid-transaction, in any state, SHALL abort it with no done pulse and no data_out update, and SHALL take priority over start.

Verification
REQ-031 T_PHASE=10, addr=0x21, start pulsed one cycle, ad_in=0x59 during D_RD -> cs_n low in cycles 1-30 and 41-70; wr_n low in cycles 11-20; rd_n low in cycles 51-60; data_out=0x59 and done=1 at cycle 71; busy=0 at cycle 72.
REQ-032 Start held high continuously, ad_in alternating 0x12/0x34 per read -> back-to-back reads exactly 72 cycles apart, data_out alternating 0x12/0x34, one done pulse per read.
REQ-033 Start pulsed at cycle 30 of a read with addr=0x55 -> ignored; ad_out stays at the original address; exactly one done pulse.
REQ-034 Reset asserted in cycle 55 (D_RD) with data_out=0x59 -> next cycle all strobes high, ad_oe=0, data_out=0x00, no done pulse.
REQ-035 T_PHASE=2, addr=0xFF, ad_in=0xA5 -> done at cycle 15, data_out=0xA5; a cycle-by-cycle checker confirms REQ-025 holds throughout.
REQ-036 ad_in changed to 0xEE in the cycle after D_RD ends -> data_out keeps the value present on the last D_RD cycle.

Source files
------------

// File: rtl/rtc_bus_reader.sv
// Reads one register from a multiplexed address/data RTC chip. Seven bus phases of
// T_PHASE cycles each, with all bus outputs driven straight from flops.
module rtc_bus_reader #(
   parameter int unsigned T_PHASE = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d_n,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_A_SETUP,
      S_A_WR,
      S_A_HOLD,
      S_TURN,
      S_D_CS,
      S_D_RD,
      S_D_HOLD,
      S_DONE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(T_PHASE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic [7:0] addr_q;
   logic       phase_end;

   logic nxt_ad_oe;
   logic nxt_cs_n;
   logic nxt_rd_n;
   logic nxt_wr_n;
   logic nxt_a_d_n;
   logic nxt_busy;
   logic nxt_done;

   assign phase_end = (cnt == CNT_LAST);

   // The address register is itself a flop, so ad_out needs no separate output stage.
   assign ad_out = addr_q;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned
   // (an unassigned path in always_comb infers a latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (start)     state_nxt = S_A_SETUP;
         S_A_SETUP: if (phase_end) state_nxt = S_A_WR;
         S_A_WR:    if (phase_end) state_nxt = S_A_HOLD;
         S_A_HOLD:  if (phase_end) state_nxt = S_TURN;
         S_TURN:    if (phase_end) state_nxt = S_D_CS;
         S_D_CS:    if (phase_end) state_nxt = S_D_RD;
         S_D_RD:    if (phase_end) state_nxt = S_D_HOLD;
         S_D_HOLD:  if (phase_end) state_nxt = S_DONE;
         S_DONE:                   state_nxt = S_IDLE;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so the registered value
   // lines up with the cycle the FSM actually spends in that state.
   always_comb begin
      nxt_ad_oe = 1'b0;
      nxt_cs_n  = 1'b1;
      nxt_rd_n  = 1'b1;
      nxt_wr_n  = 1'b1;
      nxt_a_d_n = 1'b1;
      nxt_busy  = (state_nxt != S_IDLE);
      nxt_done  = 1'b0;
      unique case (state_nxt)
         S_A_SETUP, S_A_HOLD: begin
            nxt_cs_n  = 1'b0;
            nxt_a_d_n = 1'b0;
            nxt_ad_oe = 1'b1;
         end
         S_A_WR: begin
            nxt_cs_n  = 1'b0;
            nxt_a_d_n = 1'b0;
            nxt_ad_oe = 1'b1;
            nxt_wr_n  = 1'b0;
         end
         S_D_CS, S_D_HOLD: nxt_cs_n = 1'b0;
         S_D_RD: begin
            nxt_cs_n = 1'b0;
            nxt_rd_n = 1'b0;
         end
         S_DONE:  nxt_done = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         data_out <= '0;
         ad_oe    <= 1'b0;
         cs_n     <= 1'b1;
         rd_n     <= 1'b1;
         wr_n     <= 1'b1;
         a_d_n    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state || state == S_IDLE) ? 8'd0 : cnt + 8'd1;
         if (state == S_IDLE && start)
            addr_q <= addr;
         if (state == S_D_RD && phase_end)
            data_out <= ad_in;
         ad_oe <= nxt_ad_oe;
         cs_n  <= nxt_cs_n;
         rd_n  <= nxt_rd_n;
         wr_n  <= nxt_wr_n;
         a_d_n <= nxt_a_d_n;
         busy  <= nxt_busy;
         done  <= nxt_done;
      end
   end

endmodule
